// File: rtl/sha256_msg_packer_if.sv
// sha256_msg_packer_if
// Groups the UART byte stream, the SHA-256 core handshake and the status
// pulses of the message packer into one bundle.
//   slave  : packer side (receives bytes/core flag, drives block and status)
//   master : environment side (UART receiver + SHA-256 core)
// Signals:
//   rx_dv_in     1-cycle strobe, rx_byte_in valid
//   rx_byte_in   byte from UART receiver
//   core_dv_in   core_dv_flag from SHA256_core (high while hash bytes are sent)
//   MP_dv_out    block valid to core
//   message_out  block word to core
//   busy_out     packer or core occupied
//   len_err_out  1-cycle pulse, length byte too large
//   overrun_out  1-cycle pulse, rx byte dropped
interface sha256_msg_packer_if;
    logic        rx_dv_in;
    logic [7:0]  rx_byte_in;
    logic        core_dv_in;
    logic        MP_dv_out;
    logic [31:0] message_out;
    logic        busy_out;
    logic        len_err_out;
    logic        overrun_out;

    modport slave (
        input  rx_dv_in, rx_byte_in, core_dv_in,
        output MP_dv_out, message_out, busy_out, len_err_out, overrun_out
    );

    modport master (
        output rx_dv_in, rx_byte_in, core_dv_in,
        input  MP_dv_out, message_out, busy_out, len_err_out, overrun_out
    );
endinterface

// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer
// Collects a length-prefixed byte frame, pads it into a single 512-bit
// SHA-256 block (0x80, zero fill, 64-bit big-endian bit length) and streams
// it to the SHA-256 core as 16 x 32-bit words, aligned to the core's
// dv synchroniser and LOAD phase.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  sha256_msg_packer_if.slave (byte stream in, block + status out)
//
// state   | meaning
// IDLE    | waiting for length byte L
// DISCARD | L too large, swallowing L payload bytes
// RECV    | storing payload bytes into the block buffer
// PAD     | writing 0x80, zero fill and bit length (one cycle)
// ARM     | waiting for the core to finish the previous hash
// SYNC    | dv high, zero data while the core syncs dv and enters LOAD
// SEND    | dv high, words 0..15 back-to-back
module sha256_msg_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int START_LAT  = 3,
    parameter int MAX_LEN    = 55
) (
    input logic                  clk,
    input logic                  rst,
    sha256_msg_packer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_DISCARD, S_RECV, S_PAD, S_ARM, S_SYNC, S_SEND
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_buf [0:63];
    logic [7:0]              r_len;
    logic [5:0]              r_cnt;
    logic [3:0]              r_wcnt;
    logic [3:0]              r_tmr;
    logic                    r_dv;
    logic [DATA_WIDTH-1:0]   r_msg;
    logic                    r_len_err;
    logic                    r_overrun;
    logic                    r_core_busy;
    logic                    r_core_dv_d;

    logic [3:0]              w_sel;
    logic [31:0]             w_word;
    logic                    w_drop;

    // Word to be presented next: word 0 when leaving SYNC, else the one after
    // the word currently on message_out.
    always_comb begin
        w_sel  = (r_state == S_SYNC) ? 4'd0 : r_wcnt + 4'd1;
        w_word = {r_buf[{w_sel, 2'd0}], r_buf[{w_sel, 2'd1}],
                  r_buf[{w_sel, 2'd2}], r_buf[{w_sel, 2'd3}]};
    end

    // Bytes arriving while a block is being finished or sent have nowhere to go.
    assign w_drop = bus.rx_dv_in &&
                    (r_state == S_PAD || r_state == S_ARM ||
                     r_state == S_SYNC || r_state == S_SEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= 8'd0;
            r_cnt       <= 6'd0;
            r_wcnt      <= 4'd0;
            r_tmr       <= 4'd0;
            r_dv        <= 1'b0;
            r_msg       <= '0;
            r_len_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_core_busy <= 1'b0;
            r_core_dv_d <= 1'b0;
            for (int n = 0; n < 64; n++) begin
                r_buf[n] <= 8'h00;
            end
        end else begin
            r_len_err   <= 1'b0;
            r_overrun   <= w_drop;
            r_core_dv_d <= bus.core_dv_in;
            // Core finished shifting out the hash. No bypass into ARM: the
            // cleared flag is seen there one cycle later.
            if (r_core_dv_d && !bus.core_dv_in) begin
                r_core_busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.rx_dv_in) begin
                        r_len <= bus.rx_byte_in;
                        r_cnt <= 6'd0;
                        if (bus.rx_byte_in > 8'(MAX_LEN)) begin
                            r_len_err <= 1'b1;
                            r_state   <= S_DISCARD;
                        end else if (bus.rx_byte_in == 8'd0) begin
                            r_state <= S_PAD;
                        end else begin
                            r_state <= S_RECV;
                        end
                    end
                end

                // r_len doubles as the remaining-bytes down-counter here;
                // it is never needed for padding on this path.
                S_DISCARD: begin
                    if (bus.rx_dv_in) begin
                        r_len <= r_len - 8'd1;
                        if (r_len == 8'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                // The full-frame check takes its own cycle, so a byte strobed
                // in that cycle belongs to the next frame and is dropped.
                S_RECV: begin
                    if (r_cnt == r_len[5:0]) begin
                        r_state   <= S_PAD;
                        r_overrun <= bus.rx_dv_in;
                    end else if (bus.rx_dv_in) begin
                        r_buf[r_cnt] <= bus.rx_byte_in;
                        r_cnt        <= r_cnt + 6'd1;
                    end
                end

                S_PAD: begin
                    for (int n = 0; n < 56; n++) begin
                        if (n == int'(r_len)) begin
                            r_buf[n] <= 8'h80;
                        end else if (n > int'(r_len)) begin
                            r_buf[n] <= 8'h00;
                        end
                    end
                    // 64-bit bit length = {53'b0, L, 3'b0}
                    for (int n = 56; n < 62; n++) begin
                        r_buf[n] <= 8'h00;
                    end
                    r_buf[62] <= {5'b0, r_len[7:5]};
                    r_buf[63] <= {r_len[4:0], 3'b0};
                    r_state   <= S_ARM;
                end

                S_ARM: begin
                    if (!r_core_busy) begin
                        r_dv    <= 1'b1;
                        r_msg   <= '0;
                        r_tmr   <= 4'(START_LAT - 1);
                        r_state <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    if (r_tmr == 4'd0) begin
                        r_msg   <= w_word;
                        r_wcnt  <= 4'd0;
                        r_state <= S_SEND;
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                    end
                end

                // r_wcnt is the index of the word currently on message_out.
                S_SEND: begin
                    if (r_wcnt == 4'd15) begin
                        r_dv        <= 1'b0;
                        r_msg       <= '0;
                        r_core_busy <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_msg  <= w_word;
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.MP_dv_out   = r_dv;
    assign bus.message_out = r_msg;
    assign bus.len_err_out = r_len_err;
    assign bus.overrun_out = r_overrun;
    // Decoded straight from registers so it tracks the state without a lag.
    assign bus.busy_out    = (r_state != S_IDLE && r_state != S_RECV) || r_core_busy;

endmodule

// File: tb/tb_sha256_msg_packer.sv
// tb_sha256_msg_packer
// Drives length-prefixed frames into sha256_msg_packer, emulates the core's
// dv flag and compares every streamed block with a padded block built from
// the frame payload.
module tb_sha256_msg_packer;

    logic clk = 1'b0;
    logic rst;

    sha256_msg_packer_if bus();

    sha256_msg_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_lerr;
    bit          saw_dv;
    logic [7:0]  tx_buf [0:255];
    logic [31:0] exp_w  [0:15];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Padded block from first principles: payload, 0x80, zeros, bit length.
    function automatic void build_expected(input int len);
        logic [7:0]  blk [0:63];
        logic [63:0] bits;
        for (int i = 0; i < 64; i++) blk[i] = (i < len) ? tx_buf[i] : 8'h00;
        blk[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) blk[56 + i] = 8'(bits >> (8 * (7 - i)));
        for (int k = 0; k < 16; k++)
            exp_w[k] = {blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte_in = b;
        bus.rx_dv_in   = 1'b1;
        @(negedge clk);
        bus.rx_dv_in   = 1'b0;
        if (bus.MP_dv_out)   saw_dv = 1'b1;
        if (bus.len_err_out) n_lerr++;
    endtask

    task automatic send_frame(input int len, input int max_gap);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            repeat (int'($urandom_range(0, max_gap))) @(negedge clk);
            send_byte(tx_buf[i]);
        end
    endtask

    task automatic fill_payload(input int len);
        for (int i = 0; i < len; i++) tx_buf[i] = 8'($urandom);
    endtask

    // Waits for the block, checks the sync gap, the 16 words and the dv fall.
    // inject_at: word index during which a stray byte is strobed (-1 none).
    // abort_at : word index at which reset is asserted (-1 none).
    task automatic collect(input int inject_at, input int abort_at, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.MP_dv_out && waited < 3000);
        if (!bus.MP_dv_out) begin
            check("dv_timeout", 64'(bus.MP_dv_out), 64'd1);
            return;
        end
        for (int s = 0; s < 3; s++) begin
            check($sformatf("sync%0d_dv", s), 64'(bus.MP_dv_out), 64'd1);
            check($sformatf("sync%0d_msg", s), 64'(bus.message_out), 64'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 16; k++) begin
            check($sformatf("w%0d_dv", k), 64'(bus.MP_dv_out), 64'd1);
            check($sformatf("w%0d", k), 64'(bus.message_out), 64'(exp_w[k]));
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_dv", 64'(bus.MP_dv_out), 64'd0);
                check("rst_msg", 64'(bus.message_out), 64'd0);
                check("rst_busy", 64'(bus.busy_out), 64'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == inject_at) begin
                bus.rx_byte_in = 8'hEE;
                bus.rx_dv_in   = 1'b1;
            end
            @(negedge clk);
            if (k == inject_at) begin
                bus.rx_dv_in = 1'b0;
                check("send_overrun", 64'(bus.overrun_out), 64'd1);
            end
        end
        check("end_dv", 64'(bus.MP_dv_out), 64'd0);
        check("end_msg", 64'(bus.message_out), 64'd0);
        check("end_busy", 64'(bus.busy_out), 64'd1);
    endtask

    // Core shifts out a hash, then drops its flag; busy clears next cycle.
    task automatic core_ack();
        bus.core_dv_in = 1'b1;
        repeat (4) @(negedge clk);
        bus.core_dv_in = 1'b0;
        @(negedge clk);
        check("busy_clr", 64'(bus.busy_out), 64'd0);
    endtask

    task automatic run_frame(input int len, input int gap, input int inject_at);
        int w;
        build_expected(len);
        send_frame(len, gap);
        collect(inject_at, -1, w);
        core_ack();
    endtask

    initial begin
        int w;
        int len;
        rst            = 1'b1;
        bus.rx_dv_in   = 1'b0;
        bus.rx_byte_in = 8'h00;
        bus.core_dv_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dv0", 64'(bus.MP_dv_out), 64'd0);
        check("rst_msg0", 64'(bus.message_out), 64'd0);
        check("rst_busy0", 64'(bus.busy_out), 64'd0);
        check("rst_lerr0", 64'(bus.len_err_out), 64'd0);
        check("rst_ovr0", 64'(bus.overrun_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // "abc"
        tx_buf[0] = 8'h61; tx_buf[1] = 8'h62; tx_buf[2] = 8'h63;
        build_expected(3);
        check("abc_model_w0", 64'(exp_w[0]), 64'h61626380);
        run_frame(3, 1, -1);

        // empty message
        run_frame(0, 0, -1);

        // L = 55, all 'a'
        for (int i = 0; i < 55; i++) tx_buf[i] = 8'h61;
        run_frame(55, 1, -1);

        // L = 56: length error, payload swallowed
        n_lerr = 0;
        saw_dv = 1'b0;
        send_byte(8'd56);
        check("lerr_pulse", 64'(bus.len_err_out), 64'd1);
        n_lerr = 0;
        for (int i = 0; i < 56; i++) begin
            repeat (int'($urandom_range(0, 1))) @(negedge clk);
            send_byte(8'($urandom));
        end
        check("lerr_once", 64'(n_lerr), 64'd0);
        check("discard_no_dv", 64'(saw_dv), 64'd0);
        check("discard_idle", 64'(bus.busy_out), 64'd0);
        tx_buf[0] = 8'h41;
        run_frame(1, 0, -1);

        // byte in the RECV->PAD cycle is dropped
        fill_payload(2);
        build_expected(2);
        send_frame(2, 0);
        send_byte(8'h99);
        check("recv_end_overrun", 64'(bus.overrun_out), 64'd1);
        collect(-1, -1, w);
        core_ack();

        // back-to-back: second block held until core flag falls
        tx_buf[0] = 8'h41;
        build_expected(1);
        send_frame(1, 0);
        collect(-1, -1, w);
        bus.core_dv_in = 1'b1;
        fill_payload(20);
        build_expected(20);
        send_frame(20, 2);
        repeat (10) @(negedge clk);
        check("hold_dv", 64'(bus.MP_dv_out), 64'd0);
        check("hold_busy", 64'(bus.busy_out), 64'd1);
        bus.core_dv_in = 1'b0;
        collect(5, -1, w);
        check("release_lat", 64'(w), 64'd2);
        core_ack();

        // reset in the middle of SEND, then a clean frame
        fill_payload(10);
        build_expected(10);
        send_frame(10, 1);
        collect(-1, 7, w);
        @(negedge clk);
        check("post_rst_busy", 64'(bus.busy_out), 64'd0);
        tx_buf[0] = 8'h41;
        build_expected(1);
        check("a_model_w15", 64'(exp_w[15]), 64'h8);
        run_frame(1, 0, -1);

        // random frames, some preceded by an over-length frame
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(56, 70));
                n_lerr = 0;
                saw_dv = 1'b0;
                fill_payload(len);
                send_frame(len, 1);
                check("rnd_lerr", 64'(n_lerr), 64'd1);
                check("rnd_discard_dv", 64'(saw_dv), 64'd0);
            end
            len = int'($urandom_range(0, 55));
            fill_payload(len);
            run_frame(len, 2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
